// File: rtl/seqdet_ctrl.sv
// Sequence-detector controller: serial pattern load, valid/ready stream gating,
// shift-and-compare matching with overlap/non-overlap restart, hit counting and hold-off.
module seqdet_ctrl #(
  parameter int PAT_W   = 5,
  parameter int CNT_W   = 8,
  parameter int HOLDOFF = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_start,
  input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
  input  logic                       cfg_valid,
  input  logic                       cfg_bit,
  input  logic                       run_en,
  input  logic                       overlap_en,
  input  logic                       clr_count,
  input  logic                       din,
  input  logic                       din_valid,
  output logic                       din_ready,
  output logic                       match,
  output logic [CNT_W-1:0]           match_count,
  output logic                       cfg_done,
  output logic                       err,
  output logic [1:0]                 state
);

  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam int HCW   = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [PAT_W-1:0]   pattern_r, pattern_s;
  logic [PAT_W-1:0]   history_r, history_s;
  logic [LEN_W-1:0]   fill_r, fill_s;
  logic [LEN_W-1:0]   load_cnt_r, load_cnt_s;
  logic [LEN_W-1:0]   len_r, len_s;
  logic               loaded_r, loaded_s;
  logic [HCW-1:0]     hold_cnt_r, hold_cnt_s;
  logic               match_r, match_s;
  logic [CNT_W-1:0]   count_r, count_s;
  logic               cfg_done_r, cfg_done_s;
  logic               err_r, err_s;

  logic [LEN_W-1:0]   len_eff_s;
  logic [PAT_W-1:0]   shift_hist_s;
  logic [LEN_W-1:0]   shift_fill_s;
  logic               xfer_s;
  logic               hit_s;

  // Bits at or above the active length must not take part in the compare.
  function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [PAT_W-1:0] m;
    m = '0;
    for (int i = 0; i < PAT_W; i++) begin
      m[i] = (i < int'(len)) ? 1'b1 : 1'b0;
    end
    return m;
  endfunction

  // Datapath terms: effective length, shifted history and hit detection.
  always_comb begin
    if ((cfg_len == LEN_W'(0)) || (cfg_len > LEN_W'(PAT_W))) begin
      len_eff_s = LEN_W'(PAT_W);
    end else begin
      len_eff_s = cfg_len;
    end
    shift_hist_s = {history_r[PAT_W-2:0], din};
    if (fill_r < len_r) begin
      shift_fill_s = fill_r + LEN_W'(1);
    end else begin
      shift_fill_s = len_r;
    end
    xfer_s = (state_r == RUN) && din_valid;
    hit_s  = xfer_s && (shift_fill_s >= len_r) &&
             (((shift_hist_s ^ pattern_r) & len_mask(len_r)) == '0);
  end

  // Next-state and next-register logic for the controller FSM.
  always_comb begin
    state_s    = state_r;
    pattern_s  = pattern_r;
    history_s  = history_r;
    fill_s     = fill_r;
    load_cnt_s = load_cnt_r;
    len_s      = len_r;
    loaded_s   = loaded_r;
    hold_cnt_s = hold_cnt_r;
    match_s    = 1'b0;
    cfg_done_s = 1'b0;
    err_s      = 1'b0;
    count_s    = count_r;

    case (state_r)
      IDLE: begin
        if (cfg_start) begin
          state_s    = LOAD;
          pattern_s  = '0;
          load_cnt_s = '0;
          len_s      = len_eff_s;
          loaded_s   = 1'b0;
        end else if (run_en && loaded_r) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          pattern_s  = '0;
          load_cnt_s = '0;
          len_s      = len_eff_s;
        end else if (cfg_valid) begin
          pattern_s  = {pattern_r[PAT_W-2:0], cfg_bit};
          load_cnt_s = load_cnt_r + LEN_W'(1);
          if ((load_cnt_r + LEN_W'(1)) == len_r) begin
            cfg_done_s = 1'b1;
            loaded_s   = 1'b1;
            state_s    = IDLE;
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s = LOAD;
        end
      end
      RUN: begin
        err_s = cfg_start;
        if (xfer_s) begin
          history_s = shift_hist_s;
          fill_s    = shift_fill_s;
          if (hit_s) begin
            match_s = 1'b1;
            if (!overlap_en) begin
              fill_s = '0;
            end else begin
              fill_s = shift_fill_s;
            end
          end else begin
            match_s = 1'b0;
          end
        end else begin
          history_s = history_r;
        end
        // Leaving RUN wins over entering HOLD; a final-bit hit still pulses.
        if (!run_en) begin
          state_s   = IDLE;
          history_s = '0;
          fill_s    = '0;
        end else if (hit_s && (HOLDOFF > 0)) begin
          state_s    = HOLD;
          hold_cnt_s = '0;
        end else begin
          state_s = RUN;
        end
      end
      HOLD: begin
        err_s = cfg_start;
        if (!run_en) begin
          state_s   = IDLE;
          history_s = '0;
          fill_s    = '0;
        end else if (hold_cnt_r == HCW'(HOLDOFF - 1)) begin
          state_s = RUN;
        end else begin
          hold_cnt_s = hold_cnt_r + HCW'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if (clr_count) begin
      count_s = '0;
    end else if (match_s && (count_r != {CNT_W{1'b1}})) begin
      count_s = count_r + CNT_W'(1);
    end else begin
      count_s = count_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      pattern_r  <= '0;
      history_r  <= '0;
      fill_r     <= '0;
      load_cnt_r <= '0;
      len_r      <= LEN_W'(PAT_W);
      loaded_r   <= 1'b0;
      hold_cnt_r <= '0;
      match_r    <= 1'b0;
      count_r    <= '0;
      cfg_done_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      pattern_r  <= pattern_s;
      history_r  <= history_s;
      fill_r     <= fill_s;
      load_cnt_r <= load_cnt_s;
      len_r      <= len_s;
      loaded_r   <= loaded_s;
      hold_cnt_r <= hold_cnt_s;
      match_r    <= match_s;
      count_r    <= count_s;
      cfg_done_r <= cfg_done_s;
      err_r      <= err_s;
    end
  end

  assign din_ready   = (state_r == RUN);
  assign match       = match_r;
  assign match_count = count_r;
  assign cfg_done    = cfg_done_r;
  assign err         = err_r;
  assign state       = state_r;

endmodule

// File: tb/tb_seqdet_ctrl.sv
// Scoreboard bench: two controllers (no hold-off / 8-bit count, and hold-off 3 / 2-bit count)
// share directed and random stimulus and are checked against a behavioural model.
module tb_seqdet_ctrl;

  localparam int PW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_start = 1'b0;
  logic [2:0] cfg_len = 3'd0;
  logic cfg_valid = 1'b0;
  logic cfg_bit = 1'b0;
  logic run_en = 1'b0;
  logic overlap_en = 1'b0;
  logic clr_count = 1'b0;
  logic din = 1'b0;
  logic din_valid = 1'b0;

  logic rdy0, rdy1, mt0, mt1, done0, done1, err0, err1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  logic [1:0] st0, st1;

  seqdet_ctrl #(.PAT_W(PW), .CNT_W(8), .HOLDOFF(0)) dut0 (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_valid(cfg_valid),
    .cfg_bit(cfg_bit), .run_en(run_en), .overlap_en(overlap_en), .clr_count(clr_count),
    .din(din), .din_valid(din_valid), .din_ready(rdy0), .match(mt0), .match_count(cnt0),
    .cfg_done(done0), .err(err0), .state(st0));

  seqdet_ctrl #(.PAT_W(PW), .CNT_W(2), .HOLDOFF(3)) dut1 (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_valid(cfg_valid),
    .cfg_bit(cfg_bit), .run_en(run_en), .overlap_en(overlap_en), .clr_count(clr_count),
    .din(din), .din_valid(din_valid), .din_ready(rdy1), .match(mt1), .match_count(cnt1),
    .cfg_done(done1), .err(err1), .state(st1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc; int dut; int st; int rdy; int cnt; int done; int err;
  } exp_t;
  typedef struct {
    int cyc; int cnt;
  } mev_t;

  exp_t exp_q[$];
  mev_t mq0[$];
  mev_t mq1[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: accepted bits kept as a plain integer shift record.
  int m_st[2], m_len[2], m_lcnt[2], m_since[2], m_hold[2], m_cnt[2], m_pat[2], m_hist[2];
  bit m_loaded[2];

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, expv);
    end
  endtask

  task automatic model_reset(input int i);
    m_st[i] = 0; m_pat[i] = 0; m_hist[i] = 0; m_since[i] = 0; m_lcnt[i] = 0;
    m_len[i] = PW; m_loaded[i] = 1'b0; m_cnt[i] = 0; m_hold[i] = 0;
  endtask

  task automatic model_step(input int i, input int hold_cyc, input int cmax);
    exp_t e;
    mev_t m;
    int elen, mask;
    bit hit;
    hit = 1'b0; e.done = 0; e.err = 0;
    if (rst) begin
      model_reset(i);
    end else begin
      elen = (cfg_len == 3'd0 || int'(cfg_len) > PW) ? PW : int'(cfg_len);
      case (m_st[i])
        0: begin
          if (cfg_start) begin
            m_st[i] = 1; m_pat[i] = 0; m_lcnt[i] = 0; m_len[i] = elen; m_loaded[i] = 1'b0;
          end else if (run_en && m_loaded[i]) m_st[i] = 2;
        end
        1: begin
          if (cfg_start) begin
            m_pat[i] = 0; m_lcnt[i] = 0; m_len[i] = elen;
          end else if (cfg_valid) begin
            m_pat[i] = (m_pat[i] << 1) | int'(cfg_bit);
            m_lcnt[i]++;
            if (m_lcnt[i] == m_len[i]) begin
              e.done = 1; m_loaded[i] = 1'b1; m_st[i] = 0;
            end
          end
        end
        2: begin
          e.err = int'(cfg_start);
          if (din_valid) begin
            m_hist[i] = (m_hist[i] << 1) | int'(din);
            m_since[i]++;
            mask = (1 << m_len[i]) - 1;
            if (m_since[i] >= m_len[i] && (m_hist[i] & mask) == (m_pat[i] & mask)) begin
              hit = 1'b1;
              if (!overlap_en) m_since[i] = 0;
            end
          end
          if (!run_en) begin
            m_st[i] = 0; m_hist[i] = 0; m_since[i] = 0;
          end else if (hit && hold_cyc > 0) begin
            m_st[i] = 3; m_hold[i] = hold_cyc;
          end
        end
        default: begin
          e.err = int'(cfg_start);
          if (!run_en) begin
            m_st[i] = 0; m_hist[i] = 0; m_since[i] = 0;
          end else begin
            m_hold[i]--;
            if (m_hold[i] == 0) m_st[i] = 2;
          end
        end
      endcase
      if (clr_count) m_cnt[i] = 0;
      else if (hit && m_cnt[i] < cmax) m_cnt[i]++;
    end
    e.cyc = cyc + 1; e.dut = i; e.st = m_st[i]; e.rdy = (m_st[i] == 2) ? 1 : 0; e.cnt = m_cnt[i];
    exp_q.push_back(e);
    if (hit) begin
      m.cyc = cyc + 1; m.cnt = m_cnt[i];
      if (i == 0) mq0.push_back(m);
      else mq1.push_back(m);
    end
  endtask

  task automatic step();
    model_step(0, 0, 255);
    model_step(1, 3, 3);
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int len, input int bits, input int nb);
    cfg_start = 1'b1; cfg_len = 3'(len);
    step();
    cfg_start = 1'b0;
    for (int k = nb - 1; k >= 0; k--) begin
      cfg_valid = 1'b1; cfg_bit = bits[k];
      step();
    end
    cfg_valid = 1'b0;
    step();
  endtask

  task automatic send(input int bits, input int nb, input int gap);
    for (int k = nb - 1; k >= 0; k--) begin
      din_valid = 1'b1; din = bits[k];
      step();
      din_valid = 1'b0;
      for (int g = 0; g < gap; g++) step();
    end
    din_valid = 1'b0;
    step();
    step();
  endtask

  task automatic restart_run();
    run_en = 1'b0; step();
    run_en = 1'b1; step();
  endtask

  // Monitor: per-cycle expectations plus match events consumed when match asserts.
  always @(negedge clk) begin
    exp_t e;
    mev_t m;
    int a_st[2], a_rdy[2], a_cnt[2], a_done[2], a_err[2];
    a_st[0] = int'(st0); a_rdy[0] = int'(rdy0); a_cnt[0] = int'(cnt0);
    a_done[0] = int'(done0); a_err[0] = int'(err0);
    a_st[1] = int'(st1); a_rdy[1] = int'(rdy1); a_cnt[1] = int'(cnt1);
    a_done[1] = int'(done1); a_err[1] = int'(err1);
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      chk($sformatf("state%0d", e.dut), a_st[e.dut], e.st);
      chk($sformatf("din_ready%0d", e.dut), a_rdy[e.dut], e.rdy);
      chk($sformatf("count%0d", e.dut), a_cnt[e.dut], e.cnt);
      chk($sformatf("cfg_done%0d", e.dut), a_done[e.dut], e.done);
      chk($sformatf("err%0d", e.dut), a_err[e.dut], e.err);
    end
    while (mq0.size() > 0 && mq0[0].cyc < cyc) begin
      m = mq0.pop_front();
      chk("match0_missed_cycle", cyc, m.cyc);
    end
    while (mq1.size() > 0 && mq1[0].cyc < cyc) begin
      m = mq1.pop_front();
      chk("match1_missed_cycle", cyc, m.cyc);
    end
    if (mt0) begin
      if (mq0.size() == 0) chk("match0_unexpected", 1, 0 + int'(mq0.size() > 0));
      else begin
        m = mq0.pop_front();
        chk("match0_cycle", cyc, m.cyc);
        chk("match0_count", int'(cnt0), m.cnt);
      end
    end
    if (mt1) begin
      if (mq1.size() == 0) chk("match1_unexpected", 1, 0 + int'(mq1.size() > 0));
      else begin
        m = mq1.pop_front();
        chk("match1_cycle", cyc, m.cyc);
        chk("match1_count", int'(cnt1), m.cnt);
      end
    end
  end

  initial begin
    model_reset(0);
    model_reset(1);
    rst = 1'b1;
    @(posedge clk); #1;
    step();
    rst = 1'b0;
    step();

    // Load 10101 and run overlapping, then non-overlapping, then gapped.
    load(5, 'b10101, 5);
    run_en = 1'b1; step();
    overlap_en = 1'b1;
    send('b1010101, 7, 0);
    restart_run();
    overlap_en = 1'b0;
    send('b1010101, 7, 0);
    restart_run();
    overlap_en = 1'b1;
    send('b1010101, 7, 1);

    // Illegal cfg_start while running, then confirm the pattern survives.
    cfg_start = 1'b1; cfg_len = 3'd2; step();
    cfg_start = 1'b0; step();
    restart_run();
    send('b10101, 5, 0);

    // clr_count landing on the completing bit.
    send('b1010, 4, 0);
    din_valid = 1'b1; din = 1'b1; clr_count = 1'b1; step();
    din_valid = 1'b0; clr_count = 1'b0; step(); step();

    // Length 0 means full width.
    run_en = 1'b0; step();
    load(0, 'b11001, 5);
    run_en = 1'b1; step();
    send('b110011001, 9, 0);

    // Short pattern, many hits to saturate the narrow counter.
    run_en = 1'b0; step();
    load(2, 'b11, 2);
    run_en = 1'b1; step();
    send('h3FFF, 14, 0);

    // Reset during a load leaves the controller unloaded.
    run_en = 1'b0; step();
    cfg_start = 1'b1; cfg_len = 3'd5; step();
    cfg_start = 1'b0; cfg_valid = 1'b1; cfg_bit = 1'b1; step(); step();
    cfg_valid = 1'b0; rst = 1'b1; step();
    rst = 1'b0; run_en = 1'b1; step(); step(); step();
    run_en = 1'b0; step();

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      rst        = ($urandom_range(0, 799) == 0);
      cfg_start  = ($urandom_range(0, 59) == 0);
      cfg_len    = 3'($urandom_range(0, 7));
      cfg_valid  = ($urandom_range(0, 9) < 7);
      cfg_bit    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) run_en = ~run_en;
      if ($urandom_range(0, 49) == 0) overlap_en = ~overlap_en;
      clr_count  = ($urandom_range(0, 39) == 0);
      din        = ($urandom_range(0, 9) < 6);
      din_valid  = ($urandom_range(0, 9) < 7);
      step();
    end

    rst = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; clr_count = 1'b0;
    din_valid = 1'b0; run_en = 1'b0;
    step(); step();
    @(negedge clk); #1;
    chk("exp_queue_drained", exp_q.size(), 0);
    chk("match0_queue_drained", mq0.size(), 0);
    chk("match1_queue_drained", mq1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
